dm_responder: RTL

//  Data-memory responder: the memory side of the pipeline's DM interface (DM_CEB/DM_WEB).

---
 rtl/dm_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: memory side of the pipeline's DM interface (DM_CEB/DM_WEB).
// Accepts one access per request, applies an active-low per-bit write mask,
// returns registered read data after WAIT_CYCLES wait states and raises
// dm_stall while an access is in flight. The data array is held internally.
// Optional feature macro: DM_ACCESS_CNT_EN adds saturating rd_cnt/wr_cnt outputs.
module dm_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEB,
  input  logic              WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       BWEB,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              do_valid,
  output logic              dm_stall
`ifdef DM_ACCESS_CNT_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       bweb_q, bweb_d;
  logic [31:0]       di_q, di_d;
  logic [31:0]       do_q, do_d;
  logic              do_valid_q, do_valid_d;
  logic              stall_q, stall_d;

  logic              exec_en;
  logic              exec_web;
  logic [ADDR_W-1:0] exec_a;
  logic [31:0]       exec_bweb;
  logic [31:0]       exec_di;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem_wdata;
  logic              mem_wr_en;

  // Next-state, request capture and access execution select.
  // With no wait states the live request executes at its accept edge;
  // otherwise the captured copy executes when the counter reaches zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    web_d      = web_q;
    a_d        = a_q;
    bweb_d     = bweb_q;
    di_d       = di_q;
    stall_d    = stall_q;
    exec_en    = 1'b0;
    exec_web   = web_q;
    exec_a     = a_q;
    exec_bweb  = bweb_q;
    exec_di    = di_q;
    case (state_q)
      ST_IDLE: begin
        stall_d = 1'b0;
        if (!CEB) begin
          web_d  = WEB;
          a_d    = A;
          bweb_d = BWEB;
          di_d   = DI;
          if (WAIT_CYCLES == 0) begin
            exec_en   = 1'b1;
            exec_web  = WEB;
            exec_a    = A;
            exec_bweb = BWEB;
            exec_di   = DI;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
            stall_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          exec_en = 1'b1;
          state_d = ST_IDLE;
          stall_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  // Array read/merge and read-data update for the executing access.
  always_comb begin
    mem_rdata  = mem[exec_a];
    mem_wdata  = (mem_rdata & exec_bweb) | (exec_di & ~exec_bweb);
    mem_wr_en  = exec_en & ~exec_web;
    do_d       = do_q;
    do_valid_d = 1'b0;
    if (exec_en && exec_web) begin
      do_d       = mem_rdata;
      do_valid_d = 1'b1;
    end
  end

  // Data array: not reset, written only when a write access executes.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[exec_a] <= mem_wdata;
    end
  end

  // Control, captured-request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      web_q      <= 1'b0;
      a_q        <= '0;
      bweb_q     <= '0;
      di_q       <= '0;
      do_q       <= '0;
      do_valid_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      web_q      <= web_d;
      a_q        <= a_d;
      bweb_q     <= bweb_d;
      di_q       <= di_d;
      do_q       <= do_d;
      do_valid_q <= do_valid_d;
      stall_q    <= stall_d;
    end
  end

  assign DO       = do_q;
  assign do_valid = do_valid_q;
  assign dm_stall = stall_q;

`ifdef DM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Saturating completion counters; aborted accesses never execute.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (exec_en && exec_web && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (exec_en && !exec_web && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
